// File: rtl/period_scan_ctrl.sv
// Channel scan sequencer for a shared period counter: walks the enabled channels,
// settles the input mux, runs one measurement per channel with a timeout, and reports results.
module period_scan_ctrl #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned TO_CYCLES     = 100000000,
  parameter int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned SEL_W        = $clog2(N_CH),
  localparam int unsigned PRD_W        = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              cont,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH-1:0]   si_ch,
  input  logic              pc_ready,
  input  logic              pc_done_tick,
  input  logic [PRD_W-1:0]  pc_prd,
  output logic              pc_start,
  output logic              pc_clr,
  output logic              pc_si,
  output logic [SEL_W-1:0]  sel,
  output logic              result_wr,
  output logic [SEL_W-1:0]  result_ch,
  output logic [PRD_W-1:0]  result_prd,
  output logic              result_to,
  output logic              busy,
  output logic              scan_done_tick
);

  localparam int unsigned IDX_W = SEL_W + 1;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {IDLE, SETTLE, ARM, MEAS, STORE, DONE} state_t;

  state_t             state, state_d;
  logic [SEL_W-1:0]   sel_d;
  logic [N_CH-1:0]    en_reg, en_d;
  logic [CNT_W-1:0]   to_cnt, to_d, settle_cnt, settle_d;
  logic               pc_start_d, pc_clr_d, result_wr_d, done_d, busy_d;
  logic [SEL_W-1:0]   result_ch_d;
  logic [PRD_W-1:0]   result_prd_d;
  logic               result_to_d;
  logic [IDX_W-1:0]   lo_pick, nx_pick;

  // Returns {found, index} of the lowest set bit of mask at or above floor.
  function automatic logic [IDX_W-1:0] first_set(input logic [N_CH-1:0] mask,
                                                 input logic [IDX_W-1:0] floor);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (mask[i] && (IDX_W'(i) >= floor)) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  assign lo_pick = first_set(ch_en, '0);
  assign nx_pick = first_set(en_reg, IDX_W'(sel) + IDX_W'(1));
  assign pc_si   = si_ch[sel];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      sel            <= '0;
      en_reg         <= '0;
      to_cnt         <= '0;
      settle_cnt     <= '0;
      pc_start       <= 1'b0;
      pc_clr         <= 1'b0;
      result_wr      <= 1'b0;
      result_ch      <= '0;
      result_prd     <= '0;
      result_to      <= 1'b0;
      busy           <= 1'b0;
      scan_done_tick <= 1'b0;
    end else begin
      state          <= state_d;
      sel            <= sel_d;
      en_reg         <= en_d;
      to_cnt         <= to_d;
      settle_cnt     <= settle_d;
      pc_start       <= pc_start_d;
      pc_clr         <= pc_clr_d;
      result_wr      <= result_wr_d;
      result_ch      <= result_ch_d;
      result_prd     <= result_prd_d;
      result_to      <= result_to_d;
      busy           <= busy_d;
      scan_done_tick <= done_d;
    end
  end

  // Strobes are computed on the transition so each lands in the cycle of its target state.
  always_comb begin
    state_d      = state;
    sel_d        = sel;
    en_d         = en_reg;
    to_d         = to_cnt;
    settle_d     = settle_cnt;
    pc_start_d   = 1'b0;
    pc_clr_d     = 1'b0;
    result_wr_d  = 1'b0;
    done_d       = 1'b0;
    result_ch_d  = result_ch;
    result_prd_d = result_prd;
    result_to_d  = result_to;

    case (state)
      IDLE: begin
        if (go) begin
          if (lo_pick[SEL_W]) begin
            en_d     = ch_en;
            sel_d    = lo_pick[SEL_W-1:0];
            settle_d = '0;
            state_d  = SETTLE;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      SETTLE: begin
        if ((settle_cnt + CNT_W'(1)) >= CNT_W'(SETTLE_CYCLES)) state_d = ARM;
        else settle_d = settle_cnt + CNT_W'(1);
      end
      ARM: begin
        if (pc_ready) begin
          pc_start_d = 1'b1;
          to_d       = '0;
          state_d    = MEAS;
        end
      end
      MEAS: begin
        // A completion arriving on the timeout cycle takes priority over the timeout.
        if (pc_done_tick) begin
          result_prd_d = pc_prd;
          result_to_d  = 1'b0;
          result_ch_d  = sel;
          result_wr_d  = 1'b1;
          state_d      = STORE;
        end else if (to_cnt == CNT_W'(TO_CYCLES - 1)) begin
          pc_clr_d     = 1'b1;
          result_prd_d = '1;
          result_to_d  = 1'b1;
          result_ch_d  = sel;
          result_wr_d  = 1'b1;
          state_d      = STORE;
        end else begin
          to_d = to_cnt + CNT_W'(1);
        end
      end
      STORE: begin
        if (nx_pick[SEL_W]) begin
          sel_d    = nx_pick[SEL_W-1:0];
          settle_d = '0;
          state_d  = SETTLE;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (cont && lo_pick[SEL_W]) begin
          en_d     = ch_en;
          sel_d    = lo_pick[SEL_W-1:0];
          settle_d = '0;
          state_d  = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_period_scan_ctrl.sv
// Bench for period_scan_ctrl: stub period counter, expected-event queue and a
// monitor that scores every result / scan-done strobe against it.
module tb_period_scan_ctrl;

  localparam int unsigned TO = 1000;

  typedef struct packed {
    logic       kind;  // 0 = result, 1 = scan done
    logic [1:0] ch;
    logic [9:0] prd;
    logic       to;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset, go, cont;
  logic [3:0] ch_en, si_ch;
  logic       pc_ready, pc_done_tick = 1'b0;
  logic [9:0] pc_prd = '0;
  logic       pc_start, pc_clr, pc_si;
  logic [1:0] sel, result_ch;
  logic       result_wr, result_to, busy, scan_done_tick;
  logic [9:0] result_prd;

  int         errors = 0, checks = 0;
  int         cyc = 0, start_cnt = 0, clr_cnt = 0, wr_cnt = 0;
  int         start_cyc = 0, clr_cyc = 0;
  int         dly_tab[4];
  logic [9:0] prd_tab[4];
  ev_t        exp_q[$];

  logic       stub_busy = 1'b0;
  int         stub_cnt = 0;
  logic [1:0] stub_ch = '0;

  period_scan_ctrl #(.N_CH(4), .TO_CYCLES(TO), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .go(go), .cont(cont), .ch_en(ch_en), .si_ch(si_ch),
    .pc_ready(pc_ready), .pc_done_tick(pc_done_tick), .pc_prd(pc_prd),
    .pc_start(pc_start), .pc_clr(pc_clr), .pc_si(pc_si), .sel(sel),
    .result_wr(result_wr), .result_ch(result_ch), .result_prd(result_prd),
    .result_to(result_to), .busy(busy), .scan_done_tick(scan_done_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub period counter: done pulse dly_tab[ch]+1 cycles after start; dly 0 never completes.
  assign pc_ready = ~stub_busy;
  always @(posedge clk) begin
    pc_done_tick <= 1'b0;
    if (!reset || pc_clr) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else if (pc_start) begin
      stub_busy <= 1'b1;
      stub_cnt  <= dly_tab[sel];
      stub_ch   <= sel;
    end else if (stub_busy && stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        pc_done_tick <= 1'b1;
        pc_prd       <= prd_tab[stub_ch];
        stub_busy    <= 1'b0;
      end
    end
  end

  function automatic ev_t mk(input logic kind, input logic [1:0] ch,
                             input logic [9:0] prd, input logic to);
    ev_t e;
    e.kind = kind; e.ch = ch; e.prd = prd; e.to = to;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic p_start = 1'b0, p_clr = 1'b0, p_wr = 1'b0, p_done = 1'b0;
    ev_t  e;
    forever begin
      @(negedge clk);
      if (pc_start) begin start_cnt++; start_cyc = cyc; end
      if (pc_clr) begin clr_cnt++; clr_cyc = cyc; end
      if (pc_start || pc_clr || result_wr || scan_done_tick) begin
        checks++;
        if ((pc_start && p_start) || (pc_clr && p_clr) || (result_wr && p_wr) ||
            (scan_done_tick && p_done)) begin
          errors++;
          $display("FAIL strobe_width: start=%b clr=%b wr=%b done=%b high two cycles in a row",
                   pc_start, pc_clr, result_wr, scan_done_tick);
        end
      end
      if (result_wr) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result: unexpected ch=%0d prd=%h to=%b", result_ch, result_prd, result_to);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != 1'b0 || result_ch != e.ch || result_prd != e.prd ||
              result_to != e.to || pc_si != si_ch[e.ch]) begin
            errors++;
            $display("FAIL result: got ch=%0d prd=%h to=%b si=%b expected kind=%b ch=%0d prd=%h to=%b si=%b",
                     result_ch, result_prd, result_to, pc_si, e.kind, e.ch, e.prd, e.to, si_ch[e.ch]);
          end
        end
      end
      if (scan_done_tick) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scan_done: unexpected scan_done_tick");
        end else begin
          e = exp_q.pop_front();
          if (e.kind != 1'b1) begin
            errors++;
            $display("FAIL scan_done: got scan_done_tick expected result ch=%0d prd=%h", e.ch, e.prd);
          end
        end
      end
      p_start = pc_start; p_clr = pc_clr; p_wr = result_wr; p_done = scan_done_tick;
    end
  endtask

  task automatic pulse_go();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int n = 0;
    while (start_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_start_seen"}, 32'(start_cnt >= target), 32'd1);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_sel"}, 32'(sel), 32'd0);
    chk({name, "_result_ch"}, 32'(result_ch), 32'd0);
    chk({name, "_result_prd"}, 32'(result_prd), 32'd0);
    chk({name, "_result_to"}, 32'(result_to), 32'd0);
    chk({name, "_strobes"}, 32'({pc_start, pc_clr, result_wr, scan_done_tick}), 32'd0);
  endtask

  initial begin
    int s0, w0, c0;
    reset = 1'b0; go = 1'b0; cont = 1'b0; ch_en = '0; si_ch = 4'b1010;
    for (int i = 0; i < 4; i++) begin dly_tab[i] = 3; prd_tab[i] = '0; end
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;

    // Two-channel scan, go and ch_en changes while busy must be ignored
    prd_tab[0] = 10'd20; dly_tab[0] = 5; prd_tab[2] = 10'd35; dly_tab[2] = 7;
    exp_q.push_back(mk(1'b0, 2'd0, 10'd20, 1'b0));
    exp_q.push_back(mk(1'b0, 2'd2, 10'd35, 1'b0));
    exp_q.push_back(mk(1'b1, 2'd0, 10'd0, 1'b0));
    ch_en = 4'b0101;
    pulse_go();
    ch_en = 4'b1111;
    pulse_go();
    wait_idle(200, "scan2");
    chk("scan2_starts", 32'(start_cnt), 32'd2);

    // Timeout on a silent channel
    dly_tab[1] = 0;
    exp_q.push_back(mk(1'b0, 2'd1, 10'h3FF, 1'b1));
    exp_q.push_back(mk(1'b1, 2'd0, 10'd0, 1'b0));
    ch_en = 4'b0010;
    pulse_go();
    wait_idle(1500, "timeout");
    chk("timeout_clr_delay", 32'(clr_cyc - start_cyc), 32'(TO));
    chk("timeout_clr_count", 32'(clr_cnt), 32'd1);

    // Empty mask: immediate scan done, no measurement
    s0 = start_cnt; w0 = wr_cnt;
    exp_q.push_back(mk(1'b1, 2'd0, 10'd0, 1'b0));
    ch_en = 4'b0000;
    pulse_go();
    chk("empty_done_tick", 32'(scan_done_tick), 32'd1);
    wait_idle(20, "empty");
    chk("empty_no_start", 32'(start_cnt - s0), 32'd0);
    chk("empty_no_result", 32'(wr_cnt - w0), 32'd0);

    // Continuous mode on ch3, cont dropped during the third measurement
    dly_tab[3] = 4; prd_tab[3] = 10'd50;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(1'b0, 2'd3, 10'd50, 1'b0));
      exp_q.push_back(mk(1'b1, 2'd0, 10'd0, 1'b0));
    end
    s0 = start_cnt; w0 = wr_cnt;
    cont = 1'b1; ch_en = 4'b1000;
    pulse_go();
    wait_starts(s0 + 3, 300, "cont");
    cont = 1'b0;
    wait_idle(200, "cont");
    chk("cont_results", 32'(wr_cnt - w0), 32'd3);

    // Completion on the exact timeout cycle: done wins
    dly_tab[0] = int'(TO) - 2; prd_tab[0] = 10'd77;
    c0 = clr_cnt;
    exp_q.push_back(mk(1'b0, 2'd0, 10'd77, 1'b0));
    exp_q.push_back(mk(1'b1, 2'd0, 10'd0, 1'b0));
    ch_en = 4'b0001;
    pulse_go();
    wait_idle(1500, "tie");
    chk("tie_no_clr", 32'(clr_cnt - c0), 32'd0);
    chk("tie_result_prd", 32'(result_prd), 32'd77);

    // Reset during MEAS, then a clean scan
    dly_tab[1] = 0;
    s0 = start_cnt;
    ch_en = 4'b0010;
    pulse_go();
    wait_starts(s0 + 1, 50, "midreset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    reset = 1'b1;
    dly_tab[2] = 3; prd_tab[2] = 10'd12;
    exp_q.push_back(mk(1'b0, 2'd2, 10'd12, 1'b0));
    exp_q.push_back(mk(1'b1, 2'd0, 10'd0, 1'b0));
    ch_en = 4'b0100;
    pulse_go();
    wait_idle(200, "after_reset");
    chk("after_reset_prd", 32'(result_prd), 32'd12);
    chk("after_reset_ch", 32'(result_ch), 32'd2);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/period_scan_ctrl.md
PERIOD_SCAN_CTRL -- requirements
Module: period_scan_ctrl

Interface
REQ-001 Parameter N_CH, default 4: number of measured input channels; fixed at 4 in this revision (sel width 2).
REQ-002 Parameter TO_CYCLES, default 100000000: measurement timeout in clk cycles, 2 s at 50 MHz; range 2..2^32-1.
REQ-003 Parameter SETTLE_CYCLES, default 2: cycles held after a channel switch before arming the counter.
REQ-004 clk  in  1  single system clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 go  in  1  request one scan of enabled channels; sampled only in IDLE.
REQ-007 cont  in  1  continuous mode; rescan automatically after each scan completes.
REQ-008 ch_en  in  4  channel enable mask; latched at scan start.
REQ-009 si_ch  in  4  raw channel signals to measure.
REQ-010 pc_ready  in  1  period counter idle indication.
REQ-011 pc_done_tick  in  1  period counter one-cycle completion pulse.
REQ-012 pc_prd  in  10  period counter result in ms.
REQ-013 pc_start  out  1  one-cycle start pulse to period counter.
REQ-014 pc_clr  out  1  one-cycle clear to period counter on timeout; externally ORed into its reset.
REQ-015 pc_si  out  1  combinational mux: si_ch[sel].
REQ-016 sel  out  2  currently selected channel.
REQ-017 result_wr  out  1  one-cycle result strobe.
REQ-018 result_ch  out  2  channel of the result; valid with result_wr.
REQ-019 result_prd  out  10  measured period; 10'h3FF on timeout.
REQ-020 result_to  out  1  1 = result is a timeout.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 scan_done_tick  out  1  one-cycle pulse at end of each scan.

Function
REQ-023 FSM states SHALL be IDLE, SETTLE, ARM, MEAS, STORE, DONE.
REQ-024 IDLE: on go=1 with ch_en!=0, latch en_reg=ch_en, set sel to the lowest enabled index, clear settle count, go to SETTLE; on go=1 with ch_en=0, go to DONE.
REQ-025 SETTLE: count SETTLE_CYCLES cycles with sel stable, then go to ARM.
REQ-026 ARM: wait for pc_ready=1; in that cycle assert pc_start=1, clear to_cnt to 0, go to MEAS.
REQ-027 MEAS: increment to_cnt every cycle; pc_done_tick=1 -> capture pc_prd, set to flag to 0, go to STORE.
REQ-028 MEAS: to_cnt==TO_CYCLES-1 without pc_done_tick -> assert pc_clr for that cycle, capture 10'h3FF, set to flag to 1, go to STORE.
REQ-029 pc_done_tick and timeout in the same cycle: done wins; no pc_clr.
REQ-030 STORE: result_wr=1 for one cycle with result_ch=sel and captured prd/flag; result_prd/result_to/result_ch hold until the next STORE.
REQ-031 STORE: next channel = lowest enabled index in en_reg above sel; if it exists, update sel and go to SETTLE, else go to DONE.
REQ-032 DONE: scan_done_tick=1 for one cycle; cont=1 and ch_en!=0 -> relatch en_reg, select lowest, go to SETTLE; otherwise go to IDLE.
REQ-033 go while busy SHALL be ignored; ch_en changes mid-scan SHALL NOT affect the current scan.
REQ-034 cont deasserted mid-scan: the current scan completes, then IDLE.
REQ-035 to_cnt SHALL be 32 bits, unsigned, and SHALL NOT wrap within MEAS.
REQ-036 pc_start, pc_clr, result_wr, scan_done_tick SHALL never be high two consecutive cycles.

Reset
REQ-037 reset=0 at a rising edge SHALL force IDLE, sel=0, en_reg=0, to_cnt=0, result_ch=0, result_prd=0, result_to=0 and all strobes low, including mid-MEAS.
REQ-038 During and after reset pc_clr SHALL be 0; the period counter is cleared by the shared system reset.

Verification
REQ-039 ch_en=4'b0101, go pulse, stub counter returns 10'd20 on ch0 and 10'd35 on ch2 -> result_wr twice: (ch0,20,to=0), (ch2,35,to=0); then scan_done_tick; busy low after.
REQ-040 TO_CYCLES=1000, ch_en=4'b0010, no edges on si_ch[1] -> pc_clr pulse exactly 1000 cycles after pc_start; result (ch1,3FF,to=1).
REQ-041 ch_en=0, go -> scan_done_tick one cycle later, no pc_start, no result_wr.
REQ-042 cont=1, ch_en=4'b1000 -> repeated (ch3) results each followed by scan_done_tick; clear cont mid-MEAS -> one more result then IDLE.
REQ-043 pc_done_tick on the same cycle to_cnt==TO_CYCLES-1 -> to=0, captured prd reported, pc_clr stays low.
REQ-044 reset=0 during MEAS -> next cycle busy=0, sel=0, all outputs at reset values; a subsequent go starts a clean scan.
